// File: rtl/fetch_sequencer.sv
// Multicycle instruction-fetch and PC sequencer for the first-generation core.
// It fetches over a valid/ready handshake, holds each instruction until commit, then picks the next PC.
module fetch_sequencer #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    input  logic            commit,
    input  logic [1:0]      branchjump,
    input  logic            flag,
    input  logic [XLEN-1:0] pcimm,
    input  logic [XLEN-1:0] pcjalr,
    output logic            busy,
    output logic            misalign,
    output logic [XLEN-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc_next;
    logic            pc_next_misaligned;

    assign pc4 = pc + XLEN'(4);

    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        pc_next = pc4;
        unique case (branchjump)
            2'b00: pc_next = pc4;
            2'b01: pc_next = flag ? pcimm : pc4;
            2'b10: pc_next = pcimm;
            2'b11: pc_next = {pcjalr[XLEN-1:1], 1'b0};
            default: pc_next = pc4;
        endcase
    end

    assign pc_next_misaligned = (pc_next[1:0] != 2'b00);

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start)       state_next = S_REQ;
            S_REQ:    if (imem_ready)  state_next = S_WAIT;
            S_WAIT:   if (imem_rvalid) state_next = S_EXEC;
            S_EXEC: begin
                if (commit) begin
                    // A misaligned target halts even when the core asked to continue.
                    if (pc_next_misaligned || halt) state_next = S_HALTED;
                    else                            state_next = S_REQ;
                end
            end
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            instr    <= '0;
            misalign <= 1'b0;
            instret  <= '0;
        end else begin
            state <= state_next;
            if (state == S_WAIT && imem_rvalid) begin
                instr <= imem_rdata;
            end
            if (state == S_EXEC && commit) begin
                pc      <= pc_next;
                instret <= instret + XLEN'(1);
                if (pc_next_misaligned) misalign <= 1'b1;
            end
        end
    end

    // Handshake outputs decode straight from the state, so only one can be active at a time.
    assign imem_req    = (state == S_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_EXEC);
    assign busy        = (state != S_IDLE) && (state != S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a table of commit vectors walked through one program run,
// plus directed sequences for misalignment, request stalls and reset during an outstanding fetch.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        commit;
    logic [1:0]  branchjump;
    logic        flag;
    logic [31:0] pcimm;
    logic [31:0] pcjalr;
    logic        busy;
    logic        misalign;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc4         (pc4),
        .commit      (commit),
        .branchjump  (branchjump),
        .flag        (flag),
        .pcimm       (pcimm),
        .pcjalr      (pcjalr),
        .busy        (busy),
        .misalign    (misalign),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cur_pc;
        logic [1:0]  bj;
        logic        flg;
        logic [31:0] imm;
        logic [31:0] jalr;
        logic        hlt;
        logic [31:0] next_pc;
        logic        halted;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        start       = 1'b0;
        halt        = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        commit      = 1'b0;
        branchjump  = 2'b00;
        flag        = 1'b0;
        pcimm       = '0;
        pcjalr      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; completes one fetch and leaves the DUT in EXEC.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("req_addr", imem_addr, addr);
        check("req_no_valid", {31'd0, instr_valid}, 32'd0);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("wait_req_low", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        check("exec_instr", instr, word);
        check("exec_pc", pc, addr);
        check("exec_pc4", pc4, addr + 32'd4);
    endtask

    task automatic do_commit(input logic [1:0] bj, input logic flg, input logic [31:0] imm,
                             input logic [31:0] jalr, input logic hlt);
        branchjump = bj;
        flag       = flg;
        pcimm      = imm;
        pcjalr     = jalr;
        halt       = hlt;
        commit     = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        halt   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         32'h0,   1'b0, 32'h0000_0004, 1'b0};
        vecs[1] = '{32'h0000_0004, 2'b00, 1'b0, 32'h0,         32'h0,   1'b0, 32'h0000_0008, 1'b0};
        vecs[2] = '{32'h0000_0008, 2'b01, 1'b0, 32'h40,        32'h0,   1'b0, 32'h0000_000C, 1'b0};
        vecs[3] = '{32'h0000_000C, 2'b01, 1'b1, 32'h40,        32'h0,   1'b0, 32'h0000_0040, 1'b0};
        vecs[4] = '{32'h0000_0040, 2'b10, 1'b1, 32'h100,       32'h0,   1'b0, 32'h0000_0100, 1'b0};
        vecs[5] = '{32'h0000_0100, 2'b11, 1'b0, 32'h0,         32'h201, 1'b0, 32'h0000_0200, 1'b0};
        vecs[6] = '{32'h0000_0200, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0,   1'b0, 32'hFFFF_FFFC, 1'b0};
        vecs[7] = '{32'hFFFF_FFFC, 2'b00, 1'b0, 32'h0,         32'h0,   1'b0, 32'h0000_0000, 1'b0};
        vecs[8] = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         32'h0,   1'b1, 32'h0000_0004, 1'b1};

        // Reset state.
        apply_reset();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);

        // Table-driven program run.
        start_run();
        check("start_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            do_fetch(vecs[i].cur_pc, 32'h0000_0013 + (i << 7));
            do_commit(vecs[i].bj, vecs[i].flg, vecs[i].imm, vecs[i].jalr, vecs[i].hlt);
            check("vec_pc", pc, vecs[i].next_pc);
            check("vec_instret", instret, i + 1);
            check("vec_busy", {31'd0, busy}, {31'd0, !vecs[i].halted});
            check("vec_req", {31'd0, imem_req}, {31'd0, !vecs[i].halted});
            check("vec_valid", {31'd0, instr_valid}, 32'd0);
            check("vec_misalign", {31'd0, misalign}, 32'd0);
        end
        repeat (3) @(negedge clk);
        check("halt_stays", {31'd0, busy}, 32'd0);
        check("halt_pc_hold", pc, 32'h4);

        // Misaligned JALR target: pc updates, sticky error, terminal halt even with halt=0.
        apply_reset();
        start_run();
        do_fetch(32'h0, 32'h0000_0067);
        do_commit(2'b11, 1'b0, 32'h0, 32'h206, 1'b0);
        check("mis_pc", pc, 32'h206);
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mis_req_low", {31'd0, imem_req}, 32'd0);
            check("mis_sticky", {31'd0, misalign}, 32'd1);
        end
        start = 1'b0;
        check("mis_start_ignored", {31'd0, busy}, 32'd0);
        check("mis_instret", instret, 32'd1);

        // Request stall with spurious rvalid and commit, then reset while waiting for data.
        apply_reset();
        start_run();
        do_fetch(32'h0, 32'h0000_0013);
        do_commit(2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        commit      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", imem_addr, 32'h4);
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
            check("stall_instret", instret, 32'd1);
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        commit      = 1'b0;
        check("stall_instr_kept", instr, 32'h0000_0013);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("wait_entered", {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        check("late_valid", {31'd0, instr_valid}, 32'd0);
        check("late_busy", {31'd0, busy}, 32'd0);
        check("late_pc", pc, 32'h0);
        check("late_instr", instr, 32'h0);
        check("late_instret", instret, 32'h0);
        check("late_req", {31'd0, imem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
